// File: rtl/rv_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: merges stalls, redirects, memory
// waits and halt into per-stage enables/flushes, with a wait watchdog and stall counter.
module rv_pipe_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ctrl_load_use,
    input  logic        i_ctrl_redirect_ex,
    input  logic        i_ctrl_imem_ready,
    input  logic        i_ctrl_dmem_req_mem,
    input  logic        i_ctrl_dmem_ready,
    input  logic        i_ctrl_halt_wb,
    output logic        o_ctrl_pc_en,
    output logic        o_ctrl_ifid_en,
    output logic        o_ctrl_idex_en,
    output logic        o_ctrl_exmem_en,
    output logic        o_ctrl_memwb_en,
    output logic        o_ctrl_ifid_flush,
    output logic        o_ctrl_idex_flush,
    output logic [1:0]  o_ctrl_state,
    output logic        o_ctrl_halted,
    output logic        o_ctrl_bus_err,
    output logic [31:0] o_ctrl_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   wait_q, wait_d;
    logic                   err_q, err_d;
    logic [31:0]            cnt_q, cnt_d;

    logic freeze_d;
    logic freeze_i;
    logic wait_taken;

    assign freeze_d = i_ctrl_dmem_req_mem & ~i_ctrl_dmem_ready;
    assign freeze_i = ~i_ctrl_imem_ready;

    always_comb begin
        o_ctrl_pc_en      = 1'b0;
        o_ctrl_ifid_en    = 1'b0;
        o_ctrl_idex_en    = 1'b0;
        o_ctrl_exmem_en   = 1'b0;
        o_ctrl_memwb_en   = 1'b0;
        o_ctrl_ifid_flush = 1'b0;
        o_ctrl_idex_flush = 1'b0;
        state_d           = state_q;
        wait_d            = '0;
        err_d             = err_q;
        cnt_d             = cnt_q;
        wait_taken        = 1'b0;

        if (i_rst) begin
            o_ctrl_ifid_flush = 1'b1;
            o_ctrl_idex_flush = 1'b1;
        end else if (state_q != ST_HALT) begin
            if (freeze_d) begin
                // Whole pipe frozen; a coincident redirect stays held in EX.
                state_d    = ST_DWAIT;
                wait_taken = 1'b1;
            end else if (i_ctrl_redirect_ex) begin
                o_ctrl_pc_en      = 1'b1;
                o_ctrl_ifid_en    = 1'b1;
                o_ctrl_idex_en    = 1'b1;
                o_ctrl_exmem_en   = 1'b1;
                o_ctrl_memwb_en   = 1'b1;
                o_ctrl_ifid_flush = 1'b1;
                o_ctrl_idex_flush = 1'b1;
                state_d           = ST_RUN;
            end else if (i_ctrl_load_use) begin
                o_ctrl_idex_en    = 1'b1;
                o_ctrl_exmem_en   = 1'b1;
                o_ctrl_memwb_en   = 1'b1;
                o_ctrl_idex_flush = 1'b1;
                state_d           = ST_RUN;
            end else if (freeze_i) begin
                o_ctrl_ifid_en    = 1'b1;
                o_ctrl_idex_en    = 1'b1;
                o_ctrl_exmem_en   = 1'b1;
                o_ctrl_memwb_en   = 1'b1;
                o_ctrl_ifid_flush = 1'b1;
                state_d           = ST_IWAIT;
                wait_taken        = 1'b1;
            end else begin
                o_ctrl_pc_en    = 1'b1;
                o_ctrl_ifid_en  = 1'b1;
                o_ctrl_idex_en  = 1'b1;
                o_ctrl_exmem_en = 1'b1;
                o_ctrl_memwb_en = 1'b1;
                state_d         = ST_RUN;
            end

            // D and I waits share one counter so alternating waits count as continuous.
            if (wait_taken) begin
                wait_d = wait_q + TIMEOUT_W'(1);
            end
            if (i_ctrl_halt_wb && !freeze_d) begin
                state_d = ST_HALT;
            end
            if (wait_taken && (wait_q == WAIT_LAST)) begin
                state_d = ST_HALT;
                err_d   = 1'b1;
            end
            if (!o_ctrl_pc_en && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ctrl_state     = state_q;
    assign o_ctrl_halted    = (state_q == ST_HALT) && !i_rst;
    assign o_ctrl_bus_err   = err_q;
    assign o_ctrl_stall_cnt = cnt_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed scoreboard bench for rv_pipe_ctrl: the driver queues each cycle's expected
// outputs and an independent monitor pops and compares them mid-cycle.
module tb_rv_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        load_use, redirect_ex, imem_ready, dmem_req, dmem_ready, halt_wb;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush;
    logic [1:0]  state;
    logic        halted, bus_err;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [6:0]  in;
        logic [4:0]  en;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic        h;
        logic        e;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row_idx  = 0;
    bit   done     = 0;

    rv_pipe_ctrl #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ctrl_load_use     (load_use),
        .i_ctrl_redirect_ex  (redirect_ex),
        .i_ctrl_imem_ready   (imem_ready),
        .i_ctrl_dmem_req_mem (dmem_req),
        .i_ctrl_dmem_ready   (dmem_ready),
        .i_ctrl_halt_wb      (halt_wb),
        .o_ctrl_pc_en        (pc_en),
        .o_ctrl_ifid_en      (ifid_en),
        .o_ctrl_idex_en      (idex_en),
        .o_ctrl_exmem_en     (exmem_en),
        .o_ctrl_memwb_en     (memwb_en),
        .o_ctrl_ifid_flush   (ifid_flush),
        .o_ctrl_idex_flush   (idex_flush),
        .o_ctrl_state        (state),
        .o_ctrl_halted       (halted),
        .o_ctrl_bus_err      (bus_err),
        .o_ctrl_stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in = {rst, load_use, redirect, imem_ready, dmem_req, dmem_ready, halt_wb}
    task automatic drive(input logic [6:0] in);
        {rst, load_use, redirect_ex, imem_ready, dmem_req, dmem_ready, halt_wb} = in;
    endtask

    task automatic row(input logic [6:0] in, input logic [4:0] en, input logic [1:0] fl,
                       input logic [1:0] st, input logic h, input logic e, input int cnt);
        exp_t x;
        @(posedge clk);
        #1;
        drive(in);
        x.in  = in;
        x.en  = en;
        x.fl  = fl;
        x.st  = st;
        x.h   = h;
        x.e   = e;
        x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle's outputs are a transaction.
    initial begin
        exp_t x;
        logic [6:0] act_ctrl;
        logic [3:0] act_stat;
        while (!done || exp_q.size() > 0) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                act_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
                act_stat = {state, halted, bus_err};
                $display("row %0d in=%b en/fl=%b state=%0d halted=%b err=%b stall=%0d",
                         row_idx, x.in, act_ctrl, state, halted, bus_err, stall_cnt);
                n_checks++;
                if (act_ctrl !== {x.en, x.fl}) begin
                    n_fail++;
                    $display("FAIL row %0d en_flush: got %b expected %b", row_idx, act_ctrl, {x.en, x.fl});
                end
                n_checks++;
                if (act_stat !== {x.st, x.h, x.e}) begin
                    n_fail++;
                    $display("FAIL row %0d state_halt_err: got %b expected %b", row_idx, act_stat, {x.st, x.h, x.e});
                end
                n_checks++;
                if (stall_cnt !== x.cnt) begin
                    n_fail++;
                    $display("FAIL row %0d stall_cnt: got %0d expected %0d", row_idx, stall_cnt, x.cnt);
                end
                row_idx++;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        drive(7'b1001000);
        repeat (2) @(posedge clk);
        // reset state
        row(7'b1001000, 5'b00000, 2'b11, 2'd0, 1'b0, 1'b0, 0);
        // idle run
        for (int i = 0; i < 10; i++) row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 0);
        // load-use pulse
        row(7'b0101000, 5'b00111, 2'b01, 2'd0, 1'b0, 1'b0, 0);
        row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 1);
        // data memory wait, 3 cycles then ready
        row(7'b0001100, 5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, 1);
        row(7'b0001100, 5'b00000, 2'b00, 2'd1, 1'b0, 1'b0, 2);
        row(7'b0001100, 5'b00000, 2'b00, 2'd1, 1'b0, 1'b0, 3);
        row(7'b0001110, 5'b11111, 2'b00, 2'd1, 1'b0, 1'b0, 4);
        row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 4);
        // redirect beats fetch wait
        row(7'b0010000, 5'b11111, 2'b11, 2'd0, 1'b0, 1'b0, 4);
        row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 4);
        // data freeze beats redirect, redirect applied on release
        row(7'b0010100, 5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, 4);
        row(7'b0011110, 5'b11111, 2'b11, 2'd1, 1'b0, 1'b0, 5);
        // load-use beats fetch wait
        row(7'b0100000, 5'b00111, 2'b01, 2'd0, 1'b0, 1'b0, 5);
        // alternating I/D waits trip the watchdog on the 4th consecutive cycle
        row(7'b0000000, 5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, 6);
        row(7'b0000100, 5'b00000, 2'b00, 2'd2, 1'b0, 1'b0, 7);
        row(7'b0000000, 5'b01111, 2'b10, 2'd1, 1'b0, 1'b0, 8);
        row(7'b0000000, 5'b01111, 2'b10, 2'd2, 1'b0, 1'b0, 9);
        row(7'b0001000, 5'b00000, 2'b00, 2'd3, 1'b1, 1'b1, 10);
        row(7'b0111001, 5'b00000, 2'b00, 2'd3, 1'b1, 1'b1, 10);
        // reset exits HALT
        row(7'b1001000, 5'b00000, 2'b11, 2'd3, 1'b0, 1'b1, 10);
        row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 0);
        // halt blocked by data freeze, then taken
        row(7'b0001101, 5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, 0);
        row(7'b0001001, 5'b11111, 2'b00, 2'd1, 1'b0, 1'b0, 1);
        row(7'b0001000, 5'b00000, 2'b00, 2'd3, 1'b1, 1'b0, 1);
        row(7'b1001000, 5'b00000, 2'b11, 2'd3, 1'b0, 1'b0, 1);
        // halt with a fetch wait: fetch-wait outputs, then HALT
        row(7'b0000001, 5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, 0);
        row(7'b0000000, 5'b00000, 2'b00, 2'd3, 1'b1, 1'b0, 1);
        row(7'b1001000, 5'b00000, 2'b11, 2'd3, 1'b0, 1'b0, 1);
        row(7'b0001000, 5'b11111, 2'b00, 2'd0, 1'b0, 1'b0, 0);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: monitor did not drain, %0d rows checked", row_idx);
        $fatal(1, "bench timeout");
    end

endmodule
